// File: rtl/apb_pkg.sv
// Shared types and default geometry for the APB register-memory completer.
package apb_pkg;

  localparam int APB_ADDR_WIDTH  = 8;
  localparam int APB_DATA_WIDTH  = 32;
  localparam int APB_DEPTH       = 32;
  localparam int APB_WAIT_STATES = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_mem.sv
// Word-addressed register array: synchronous write, registered read port,
// synchronous clear on reset.
module apb_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [IDX_WIDTH-1:0]  idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Storage array update and read-data register; rd_zero forces the error read value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (wr_en) begin
        mem_r[idx] <= wdata;
      end
      if (rd_zero) begin
        rdata_r <= {DATA_WIDTH{1'b0}};
      end else if (rd_en) begin
        rdata_r <= mem_r[idx];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/apb_slave.sv
// APB3 completer in front of apb_mem: protocol FSM, wait-state counter,
// address range check and registered pready/pslver.
module apb_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int DEPTH       = APB_DEPTH,
  parameter int WAIT_STATES = APB_WAIT_STATES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic                  pslver,
  output logic [DATA_WIDTH-1:0] prdata
);

  localparam int IDX_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = $clog2(WAIT_STATES + 2);

  apb_state_e           state_r, state_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_s, eff_cnt_s;
  logic                 pready_r, pslver_r;
  logic                 access_s, done_s, in_range_s;
  logic                 wr_en_s, rd_en_s, rd_zero_s;

  assign in_range_s = ({1'b0, paddr} < (ADDR_WIDTH + 1)'(DEPTH));

  // Next-state, wait-count and completion decode.
  // The SETUP->ACCESS edge is the first access edge and counts as count 0,
  // so WAIT_STATES=0 completes on the edge right after penable rises.
  always_comb begin
    state_s   = state_r;
    access_s  = 1'b0;
    eff_cnt_s = (state_r == ACCESS) ? cnt_r : {CNT_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (psel && !penable) begin
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (!psel) begin
          state_s = IDLE;
        end else if (penable) begin
          state_s  = ACCESS;
          access_s = 1'b1;
        end else begin
          state_s = SETUP;
        end
      end
      ACCESS: begin
        // With pready up, this edge is where the requester finishes.
        if (pready_r) begin
          state_s = psel ? SETUP : IDLE;
        end else if (!psel) begin
          state_s = IDLE;
        end else begin
          state_s  = ACCESS;
          access_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    done_s = access_s && (eff_cnt_s == CNT_WIDTH'(WAIT_STATES));
    if (access_s && !done_s) begin
      cnt_s = eff_cnt_s + CNT_WIDTH'(1);
    end else begin
      cnt_s = {CNT_WIDTH{1'b0}};
    end
  end

  assign wr_en_s   = done_s && pwrite && in_range_s;
  assign rd_en_s   = done_s && !pwrite && in_range_s;
  assign rd_zero_s = done_s && !in_range_s;

  // FSM, counter and handshake output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_WIDTH{1'b0}};
      pready_r <= 1'b0;
      pslver_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      pready_r <= done_s;
      pslver_r <= rd_zero_s;
    end
  end

  apb_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .rd_en   (rd_en_s),
    .rd_zero (rd_zero_s),
    .idx     (paddr[IDX_WIDTH-1:0]),
    .wdata   (pwdata),
    .rdata   (prdata)
  );

  assign pready = pready_r;
  assign pslver = pslver_r;

endmodule

// File: tb/tb_apb_slave.sv
// Directed self-checking bench: one zero-wait instance and one WAIT_STATES=3 instance.
module tb_apb_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel_a = 1'b0;
  logic        psel_b = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = 8'd0;
  logic [31:0] pwdata = 32'd0;
  logic        pready_a, pslver_a, pready_b, pslver_b;
  logic [31:0] prdata_a, prdata_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb_slave dut (
    .clk(clk), .rst(rst), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_a), .pslver(pslver_a), .prdata(prdata_a)
  );

  apb_slave #(.WAIT_STATES(3)) dut_ws (
    .clk(clk), .rst(rst), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_b), .pslver(pslver_b), .prdata(prdata_b)
  );

  // One transfer; returns after the cycle where pready is seen, psel/penable still high.
  task automatic xfer(input bit ws, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int edges);
    @(posedge clk); #1;
    if (ws) psel_b = 1'b1; else psel_a = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    edges = -1; rd = 32'd0; err = 1'b0;
    for (int i = 1; i <= 20 && edges < 0; i++) begin
      @(posedge clk); #1;
      if ((ws ? pready_b : pready_a) === 1'b1) begin
        edges = i;
        rd    = ws ? prdata_b : prdata_a;
        err   = ws ? pslver_b : pslver_a;
      end
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    n_cmp++; if (pready_a !== 1'b0) begin n_bad++; $display("FAIL reset_pready got %b exp 0", pready_a); end
    n_cmp++; if (pslver_a !== 1'b0) begin n_bad++; $display("FAIL reset_pslver got %b exp 0", pslver_a); end
    n_cmp++; if (prdata_a !== 32'd0) begin n_bad++; $display("FAIL reset_prdata got %h exp 0", prdata_a); end
    n_cmp++; if (pready_b !== 1'b0) begin n_bad++; $display("FAIL reset_pready_ws got %b exp 0", pready_b); end
    n_cmp++; if (prdata_b !== 32'd0) begin n_bad++; $display("FAIL reset_prdata_ws got %h exp 0", prdata_b); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int e;
    xfer(1'b0, 1'b1, 8'd5, 32'h0000_0001, rd, err, e);
    n_cmp++; if (e !== 1) begin n_bad++; $display("FAIL wr5_latency got %0d exp 1", e); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr5_pslver got %b exp 0", err); end
    xfer(1'b0, 1'b0, 8'd5, 32'h0, rd, err, e);
    n_cmp++; if (e !== 1) begin n_bad++; $display("FAIL rd5_latency got %0d exp 1", e); end
    n_cmp++; if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL rd5_data got %h exp 00000001", rd); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rd5_pslver got %b exp 0", err); end
    go_idle();
    n_cmp++; if (pready_a !== 1'b0) begin n_bad++; $display("FAIL rd5_pulse got %b exp 0", pready_a); end
    @(posedge clk); #1;
    n_cmp++; if (prdata_a !== 32'h0000_0001) begin n_bad++; $display("FAIL prdata_hold got %h exp 00000001", prdata_a); end
    n_cmp++; if (pslver_a !== 1'b0) begin n_bad++; $display("FAIL pslver_idle got %b exp 0", pslver_a); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err; int e;
    xfer(1'b0, 1'b1, 8'd40, 32'hDEAD_BEEF, rd, err, e);
    n_cmp++; if (e !== 1) begin n_bad++; $display("FAIL oob_wr_latency got %0d exp 1", e); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oob_wr_pslver got %b exp 1", err); end
    xfer(1'b0, 1'b0, 8'd40, 32'h0, rd, err, e);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL oob_rd_data got %h exp 0", rd); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oob_rd_pslver got %b exp 1", err); end
    go_idle();
    // whole memory: only word 5 may be non-zero
    for (int i = 0; i < 32; i++) begin
      xfer(1'b0, 1'b0, 8'(i), 32'h0, rd, err, e);
      n_cmp++;
      if (rd !== ((i == 5) ? 32'h0000_0001 : 32'd0) || err !== 1'b0 || e !== 1) begin
        n_bad++; $display("FAIL mem_scan[%0d] got %h err %b lat %0d exp %h err 0 lat 1",
                          i, rd, err, e, (i == 5) ? 32'h1 : 32'h0);
      end
    end
    go_idle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int e;
    xfer(1'b1, 1'b1, 8'd2, 32'hA5A5_0002, rd, err, e);
    n_cmp++; if (e !== 4) begin n_bad++; $display("FAIL ws_wr_latency got %0d exp 4", e); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ws_wr_pslver got %b exp 0", err); end
    go_idle();
    n_cmp++; if (pready_b !== 1'b0) begin n_bad++; $display("FAIL ws_pulse got %b exp 0", pready_b); end
    xfer(1'b1, 1'b0, 8'd2, 32'h0, rd, err, e);
    n_cmp++; if (e !== 4) begin n_bad++; $display("FAIL ws_rd_latency got %0d exp 4", e); end
    n_cmp++; if (rd !== 32'hA5A5_0002) begin n_bad++; $display("FAIL ws_rd_data got %h exp a5a50002", rd); end
    go_idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int e;
    @(posedge clk); #1;
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd2; pwdata = 32'h1234_5678;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (pready_b !== 1'b0) begin n_bad++; $display("FAIL abort_early_pready got %b exp 0", pready_b); end
    psel_b = 1'b0; penable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (pready_b !== 1'b0) begin n_bad++; $display("FAIL abort_late_pready got %b exp 0", pready_b); end
    xfer(1'b1, 1'b0, 8'd2, 32'h0, rd, err, e);
    n_cmp++; if (rd !== 32'hA5A5_0002) begin n_bad++; $display("FAIL abort_old_data got %h exp a5a50002", rd); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int e;
    xfer(1'b0, 1'b1, 8'd7, 32'h0000_0077, rd, err, e);
    xfer(1'b0, 1'b0, 8'd5, 32'h0, rd, err, e);
    go_idle();
    @(posedge clk); #1;
    psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pwdata = 32'h0000_0033;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; psel_b = 1'b0; penable = 1'b0;
    n_cmp++; if (pready_b !== 1'b0 || pslver_b !== 1'b0) begin n_bad++; $display("FAIL midrst_ws_flags got %b%b exp 00", pready_b, pslver_b); end
    n_cmp++; if (prdata_a !== 32'd0) begin n_bad++; $display("FAIL midrst_prdata got %h exp 0", prdata_a); end
    xfer(1'b0, 1'b0, 8'd5, 32'h0, rd, err, e);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL midrst_mem5 got %h exp 0", rd); end
    xfer(1'b0, 1'b0, 8'd7, 32'h0, rd, err, e);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL midrst_mem7 got %h exp 0", rd); end
    go_idle();
    xfer(1'b1, 1'b0, 8'd2, 32'h0, rd, err, e);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL midrst_ws_mem2 got %h exp 0", rd); end
    xfer(1'b1, 1'b0, 8'd3, 32'h0, rd, err, e);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL midrst_ws_mem3 got %h exp 0", rd); end
    go_idle();
  endtask

  task automatic test_no_setup();
    logic [31:0] rd; logic err; int e;
    @(posedge clk); #1;
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd4; pwdata = 32'h0000_0044;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (pready_a !== 1'b0) begin n_bad++; $display("FAIL nosetup_pready[%0d] got %b exp 0", i, pready_a); end
    end
    psel_a = 1'b0; penable = 1'b0;
    xfer(1'b0, 1'b0, 8'd4, 32'h0, rd, err, e);
    n_cmp++; if (e !== 1 || rd !== 32'd0) begin n_bad++; $display("FAIL nosetup_mem4 got %h lat %0d exp 0 lat 1", rd, e); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_wait_states();
    test_abort();
    test_reset_mid();
    test_no_setup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_slave.md
# apb_slave

APB3-style completer (slave) that fronts a small word-addressed register memory. It accepts single read/write transfers from one APB requester and returns a registered `pready` handshake, read data and a slave-error flag. The block sits behind the system APB bridge, and its signals match the project's `intf` APB bundle.

## Interface
- `ADDR_WIDTH`, 8: width of `paddr`, byte-free word address.
- `DATA_WIDTH`, 32: width of `pwdata`/`prdata` and of each memory word.
- `DEPTH`, 32: number of memory words. Valid addresses are 0..DEPTH-1.
- `WAIT_STATES`, 0: extra ACCESS cycles inserted before `pready` is raised.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `psel`  in  1  slave select.
- `penable`  in  1  access phase strobe.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_WIDTH  word address.
- `pwdata`  in  DATA_WIDTH  write data.
- `pready`  out  1  transfer-complete, registered.
- `pslver`  out  1  slave error, valid only while `pready`=1.
- `prdata`  out  DATA_WIDTH  read data, valid only while `pready`=1 on a read.

## Operation
- **FSM states.** IDLE, SETUP, ACCESS. The state is registered and sampled at each edge.
  - IDLE: stays in IDLE while `psel`=0. Goes to SETUP when `psel`=1 and `penable`=0.
  - SETUP: goes to ACCESS when `psel`=1 and `penable`=1. Returns to IDLE when `psel`=0.
  - ACCESS: on a completion edge (see Timing), goes to SETUP if `psel` is still 1, otherwise to IDLE. Dropping `psel` before completion aborts the transfer, returns to IDLE and performs no write.
- **Protocol violation.** `penable`=1 seen in IDLE (no setup phase) is ignored: no response and no state change.
- **Write.** At the completion edge, `mem[paddr] <= pwdata` when `paddr < DEPTH`.
- **Read.** At the completion edge, `prdata <= mem[paddr]` when `paddr < DEPTH`.
- **Error.** If `paddr >= DEPTH`:
  - `pslver`=1 together with `pready`;
  - the write is suppressed and the memory is unchanged;
  - `prdata` = 0.
- **Address and data sampling.** `paddr`, `pwrite` and `pwdata` are sampled at the completion edge. The requester must hold them stable from SETUP through completion.
- **Outputs outside a completion cycle.** `prdata` holds its last value. `pslver` is 0.

## Timing
- **Reset.** On an edge with `rst`=0:
  - `pready`=0, `pslver`=0, `prdata`=0;
  - all memory words = 0;
  - FSM to IDLE, wait counter = 0.
- **Reset mid-transfer.** Aborts the transfer; no write occurs.
- **Wait counter.** Cleared on entry to ACCESS and incremented each ACCESS edge while `pready`=0.
- **Completion edge.** The first ACCESS edge with counter == WAIT_STATES. At that edge, `pready` <= 1 and the write/read/error action is taken.
- **Pulse width.** `pready` is high for exactly one cycle and is cleared on the next edge.
- **Latency with WAIT_STATES=0.** `penable` rises, and the next edge is the completion edge. `pready` is visible the following cycle; the requester completes at the edge after that, so each transfer takes 3 cycles. With WAIT_STATES=N, add N cycles.
- **Back-to-back transfers.** After completion, the requester may keep `psel`=1 and drop `penable`; this is a new SETUP with no IDLE cycle.
- **Read-after-write.** A read of an address in the very next transfer returns the new data.

## Structure
- **Shared package `apb_pkg`.**
  - State typedef `apb_state_e` (IDLE, SETUP, ACCESS).
  - Default width and depth constants.
- **Sub-module `apb_mem`.**
  - DEPTH×DATA_WIDTH register array with synchronous write, registered read and synchronous clear on reset.
- **Top level `apb_slave`.**
  - FSM, wait counter, address-range check and output registers.

## Test plan
- **Reset.** Hold `rst`=0 for 2 cycles, then release → `pready`=0, `pslver`=0, `prdata`=0, all memory words 0.
- **Write then read.** Write 0x00000001 to address 5, then keep `psel`=1, set `pwrite`=0 and read address 5 → `prdata`=0x00000001 with `pready`, `pslver`=0, `mem[5]`=1, all other words 0.
- **Out-of-range address.** Write 0xDEADBEEF to address 40 (DEPTH=32) → `pslver`=1 with `pready`, memory unchanged. A read of address 40 → `prdata`=0, `pslver`=1.
- **Wait states.** With WAIT_STATES=3, write address 2 → `pready` rises 4 edges after `penable`=1 and is high for exactly 1 cycle.
- **Abort.** Drop `psel` during ACCESS before `pready` → no write; a later read of that address returns the old value.
- **Reset mid-transfer and missing setup.**
  - Assert `rst`=0 during ACCESS → outputs 0 and memory cleared.
  - Drive `penable`=1 with no prior SETUP → no `pready`.
